ant_swarm_scheduler: RTL and testbench

- Parametrised multi-ant sequencer between board/host controls and an array of ANT_NUM ant instances.
- Setup phase: loads per-ant config words over a valid/ready handshake into one-hot SET strobes.
- Run phase: issues timed or manual sweeps that strobe each ant's moveNow in turn, holding the global write flag, then pulses newLocClock once per completed step.
- Also resolves which ant, if any, occupies the pixel currently being drawn, for the colour mapper.

---
 rtl/ant_sched_pkg.sv | 20 ++
 rtl/ant_swarm_scheduler_if.sv | 21 ++
 rtl/ant_render_match.sv | 30 +++
 rtl/ant_swarm_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_ant_swarm_scheduler.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ant_sched_pkg.sv
// Shared types and constants for the ant swarm scheduler.
package ant_sched_pkg;

    // Arena geometry and ant config word width used as default parameters
    localparam int X_bits   = 8;
    localparam int Y_bits   = 7;
    localparam int ANT_bits = 34;

    // Width of the completed-sweep counter
    localparam int STEP_BITS = 16;

    // Sequencer states; encoding is visible on the debug state port
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SWEEP = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/ant_swarm_scheduler_if.sv
// Config-word handshake between a host loader and the scheduler.
interface ant_swarm_scheduler_if #(
    parameter int ID_BITS  = 3,
    parameter int ANT_BITS = 34
);
    logic                cfg_valid;
    logic                cfg_ready;
    logic [ID_BITS-1:0]  cfg_id;
    logic [ANT_BITS-1:0] cfg_data;
    logic                cfg_err;

    modport master (
        output cfg_valid, cfg_id, cfg_data,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_id, cfg_data,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/ant_render_match.sv
// Finds whether any ant sits on the render pixel and which lowest-index ant it is.
module ant_render_match #(
    parameter int ANT_NUM = 8,
    parameter int X_BITS  = 8,
    parameter int Y_BITS  = 7,
    parameter int ID_BITS = $clog2(ANT_NUM)
) (
    input  logic [ANT_NUM*X_BITS-1:0] i_ant_x,
    input  logic [ANT_NUM*Y_BITS-1:0] i_ant_y,
    input  logic [X_BITS-1:0]         i_render_x,
    input  logic [Y_BITS-1:0]         i_render_y,
    output logic                      o_hit,
    output logic [ID_BITS-1:0]        o_id
);

    // Position compare per ant; first match in index order wins
    always_comb begin
        o_hit = 1'b0;
        o_id  = '0;
        for (int unsigned i = 0; i < ANT_NUM; i++) begin
            if (!o_hit &&
                i_ant_x[i*X_BITS +: X_BITS] == i_render_x &&
                i_ant_y[i*Y_BITS +: Y_BITS] == i_render_y) begin
                o_hit = 1'b1;
                o_id  = ID_BITS'(i);
            end
        end
    end

endmodule

// File: rtl/ant_swarm_scheduler.sv
// Multi-ant sequencer: config load, timed/manual move sweeps, render pixel lookup.
module ant_swarm_scheduler
    import ant_sched_pkg::*;
#(
    parameter int ANT_NUM  = 8,
    parameter int X_BITS   = X_bits,
    parameter int Y_BITS   = Y_bits,
    parameter int ANT_BITS = ANT_bits,
    parameter int STEP_DIV = 50000,
    parameter int ID_BITS  = $clog2(ANT_NUM)
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       setup_mode,
    ant_swarm_scheduler_if.slave       cfg,
    output logic [ANT_NUM-1:0]         ant_set,
    output logic [ANT_BITS-1:0]        ant_d_in,
    input  logic                       run_en,
    input  logic                       step_req,
    input  logic [ANT_NUM-1:0]         ant_busy,
    output logic [ANT_NUM-1:0]         move_now,
    output logic                       write_flag,
    output logic                       new_loc_clk,
    input  logic [ANT_NUM*X_BITS-1:0]  ant_x,
    input  logic [ANT_NUM*Y_BITS-1:0]  ant_y,
    input  logic [X_BITS-1:0]          render_x,
    input  logic [Y_BITS-1:0]          render_y,
    output logic                       render_ant,
    output logic [ID_BITS-1:0]         render_id,
    output logic [STEP_BITS-1:0]       step_count,
    output logic                       overrun,
    output logic [1:0]                 state
);

    localparam int                    DIV_BITS = $clog2(STEP_DIV);
    localparam logic [DIV_BITS-1:0]   DIV_LAST = DIV_BITS'(STEP_DIV - 1);
    localparam logic [ID_BITS-1:0]    IDX_LAST = ID_BITS'(ANT_NUM - 1);

    sched_state_t          r_state;
    logic [ID_BITS-1:0]    r_idx;
    logic [DIV_BITS-1:0]   r_div;
    logic                  r_tick;
    logic                  r_step_prev;
    logic                  r_write;
    logic                  r_new_loc;
    logic [STEP_BITS-1:0]  r_step_count;
    logic                  r_overrun;
    logic [ANT_NUM-1:0]    r_ant_set;
    logic [ANT_BITS-1:0]   r_d_in;
    logic                  r_cfg_err;
    logic                  r_render_ant;
    logic [ID_BITS-1:0]    r_render_id;

    logic                  w_manual;
    logic                  w_trig;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_id_ok;
    logic                  w_sweep_go;
    logic                  w_hit;
    logic [ID_BITS-1:0]    w_hit_id;

    assign w_manual   = step_req & ~r_step_prev;
    assign w_trig     = r_tick | w_manual;
    assign w_ready    = (r_state == LOAD) && setup_mode;
    assign w_accept   = cfg.cfg_valid && w_ready;
    assign w_id_ok    = 32'(cfg.cfg_id) < 32'(ANT_NUM);
    // Busy stalls must take effect in the same cycle, so the strobe is gated combinationally
    assign w_sweep_go = (r_state == SWEEP) && !setup_mode && (ant_busy == '0);

    assign cfg.cfg_ready = w_ready;
    assign cfg.cfg_err   = r_cfg_err;
    assign ant_set       = r_ant_set;
    assign ant_d_in      = r_d_in;
    assign move_now      = w_sweep_go ? (ANT_NUM'(1) << r_idx) : '0;
    assign write_flag    = r_write;
    assign new_loc_clk   = r_new_loc;
    assign step_count    = r_step_count;
    assign overrun       = r_overrun;
    assign state         = r_state;
    assign render_ant    = r_render_ant;
    assign render_id     = r_render_id;

    // Sequencer: step divider, trigger detection, load/sweep/done control
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_div        <= '0;
            r_tick       <= 1'b0;
            r_step_prev  <= 1'b0;
            r_write      <= 1'b0;
            r_new_loc    <= 1'b0;
            r_step_count <= '0;
            r_overrun    <= 1'b0;
        end else begin
            r_step_prev <= step_req;
            r_tick      <= 1'b0;
            r_new_loc   <= 1'b0;
            if (r_state == IDLE && run_en) begin
                r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_BITS'(1);
            end else begin
                r_div <= '0;
            end
            if (w_trig && r_state != IDLE) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (setup_mode) begin
                        r_state <= LOAD;
                    end else if (w_trig) begin
                        r_state <= SWEEP;
                        r_idx   <= '0;
                        r_write <= 1'b1;
                    end else begin
                        // Tick is registered so it only ever lands while still idle
                        r_tick <= run_en && (r_div == DIV_LAST);
                    end
                end
                LOAD: begin
                    if (!setup_mode) begin
                        r_state <= IDLE;
                    end
                end
                SWEEP: begin
                    if (setup_mode) begin
                        r_state <= LOAD;
                        r_write <= 1'b0;
                    end else if (w_sweep_go) begin
                        if (r_idx == IDX_LAST) begin
                            r_state      <= DONE;
                            r_write      <= 1'b0;
                            r_new_loc    <= 1'b1;
                            r_step_count <= r_step_count + STEP_BITS'(1);
                        end else begin
                            r_idx <= r_idx + ID_BITS'(1);
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Config path: accepted word becomes a one-cycle one-hot SET strobe
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ant_set <= '0;
            r_d_in    <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_ant_set <= '0;
            if (w_accept) begin
                r_d_in <= cfg.cfg_data;
                if (w_id_ok) begin
                    r_ant_set <= ANT_NUM'(1) << cfg.cfg_id;
                end else begin
                    r_cfg_err <= 1'b1;
                end
            end
        end
    end

    ant_render_match #(
        .ANT_NUM (ANT_NUM),
        .X_BITS  (X_BITS),
        .Y_BITS  (Y_BITS),
        .ID_BITS (ID_BITS)
    ) u_render_match (
        .i_ant_x    (ant_x),
        .i_ant_y    (ant_y),
        .i_render_x (render_x),
        .i_render_y (render_y),
        .o_hit      (w_hit),
        .o_id       (w_hit_id)
    );

    // Render lookup register, independent of sequencer state
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_render_ant <= 1'b0;
            r_render_id  <= '0;
        end else begin
            r_render_ant <= w_hit;
            r_render_id  <= w_hit_id;
        end
    end

endmodule

// File: tb/tb_ant_swarm_scheduler.sv
// Scoreboard bench for ant_swarm_scheduler (4 ants, short step divider).
module tb_ant_swarm_scheduler;
    import ant_sched_pkg::*;

    localparam int N  = 4;
    localparam int XB = 8;
    localparam int YB = 7;
    localparam int AB = 34;
    localparam int SD = 16;
    localparam int IB = 3;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              setup_mode = 1'b0;
    logic [N-1:0]      ant_set;
    logic [AB-1:0]     ant_d_in;
    logic              run_en = 1'b0;
    logic              step_req = 1'b0;
    logic [N-1:0]      ant_busy = '0;
    logic [N-1:0]      move_now;
    logic              write_flag;
    logic              new_loc_clk;
    logic [N*XB-1:0]   ant_x = '0;
    logic [N*YB-1:0]   ant_y = '0;
    logic [XB-1:0]     render_x = '0;
    logic [YB-1:0]     render_y = '0;
    logic              render_ant;
    logic [IB-1:0]     render_id;
    logic [15:0]       step_count;
    logic              overrun;
    logic [1:0]        state;

    ant_swarm_scheduler_if #(.ID_BITS(IB), .ANT_BITS(AB)) cfg_bus ();

    ant_swarm_scheduler #(
        .ANT_NUM  (N),
        .X_BITS   (XB),
        .Y_BITS   (YB),
        .ANT_BITS (AB),
        .STEP_DIV (SD),
        .ID_BITS  (IB)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .setup_mode  (setup_mode),
        .cfg         (cfg_bus),
        .ant_set     (ant_set),
        .ant_d_in    (ant_d_in),
        .run_en      (run_en),
        .step_req    (step_req),
        .ant_busy    (ant_busy),
        .move_now    (move_now),
        .write_flag  (write_flag),
        .new_loc_clk (new_loc_clk),
        .ant_x       (ant_x),
        .ant_y       (ant_y),
        .render_x    (render_x),
        .render_y    (render_y),
        .render_ant  (render_ant),
        .render_id   (render_id),
        .step_count  (step_count),
        .overrun     (overrun),
        .state       (state)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct { int stamp; logic [N-1:0] hot; logic [AB-1:0] data; } set_t;
    typedef struct { int stamp; logic hit; logic [IB-1:0] id; } rend_t;
    typedef struct { logic [15:0] cnt; int len; int period; } done_t;

    set_t         q_set[$];
    logic [N-1:0] q_move[$];
    done_t        q_done[$];
    rend_t        q_rend[$];

    logic [XB-1:0] ax[N];
    logic [YB-1:0] ay[N];
    logic [XB-1:0] rx;
    logic [YB-1:0] ry;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    // Reference: the lowest-index ant on the render pixel, scanned from the top down
    function automatic rend_t model_render(input int stamp);
        rend_t r;
        r.stamp = stamp;
        r.hit   = 1'b0;
        r.id    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (ax[i] == rx && ay[i] == ry) begin
                r.hit = 1'b1;
                r.id  = IB'(i);
            end
        end
        return r;
    endfunction

    task automatic apply_render();
        for (int i = 0; i < N; i++) begin
            ant_x[i*XB +: XB] = ax[i];
            ant_y[i*YB +: YB] = ay[i];
        end
        render_x = rx;
        render_y = ry;
        q_rend.push_back(model_render(cyc + 1));
        step();
    endtask

    task automatic send(input int id, input logic [AB-1:0] data);
        set_t e;
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_id    = IB'(id);
        cfg_bus.cfg_data  = data;
        if (id < N) begin
            e.stamp = cyc + 1;
            e.hot   = N'(1) << id;
            e.data  = data;
            q_set.push_back(e);
        end
        step();
    endtask

    task automatic push_sweep(input int moves);
        for (int i = 0; i < moves; i++) q_move.push_back(N'(1) << i);
    endtask

    task automatic push_done(input int cnt, input int len, input int period);
        done_t d;
        d.cnt    = 16'(cnt);
        d.len    = len;
        d.period = period;
        q_done.push_back(d);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (q_done.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk("sweep_done_timeout", 64'(q_done.size()), 0);
    endtask

    // Monitor: pops expected responses whenever the DUT presents an output
    int first_move = 0;
    int last_done  = 0;
    always @(negedge Clk) begin : monitor
        set_t         se;
        rend_t        re;
        done_t        de;
        logic [N-1:0] me;
        if (!Reset) begin
            if (q_set.size() != 0 && q_set[0].stamp == cyc) begin
                se = q_set.pop_front();
                chk("ant_set", 64'(ant_set), 64'(se.hot));
                chk("ant_d_in", 64'(ant_d_in), 64'(se.data));
            end else if (ant_set != '0) begin
                chk("ant_set_unexpected", 64'(ant_set), 0);
            end
            if (ant_busy != '0) chk("move_while_busy", 64'(move_now), 0);
            if (move_now != '0) begin
                if (q_move.size() == 0) begin
                    chk("move_unexpected", 64'(move_now), 0);
                end else begin
                    me = q_move.pop_front();
                    chk("move_now", 64'(move_now), 64'(me));
                    chk("write_flag_sweep", 64'(write_flag), 1);
                    if (me == N'(1)) first_move = cyc;
                end
            end
            if (new_loc_clk) begin
                if (q_done.size() == 0) begin
                    chk("new_loc_unexpected", 64'(new_loc_clk), 0);
                end else begin
                    de = q_done.pop_front();
                    chk("step_count", 64'(step_count), 64'(de.cnt));
                    chk("sweep_len", 64'(cyc - first_move), 64'(de.len));
                    if (de.period != 0) chk("sweep_period", 64'(cyc - last_done), 64'(de.period));
                    chk("write_flag_done", 64'(write_flag), 0);
                end
                last_done = cyc;
            end
            if (q_rend.size() != 0 && q_rend[0].stamp == cyc) begin
                re = q_rend.pop_front();
                chk("render_ant", 64'(render_ant), 64'(re.hit));
                chk("render_id", 64'(render_id), 64'(re.id));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [63:0] r64;
        int          id;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_id    = '0;
        cfg_bus.cfg_data  = '0;

        // Reset state
        step();
        step();
        chk("rst_state", 64'(state), 64'(IDLE));
        chk("rst_move_now", 64'(move_now), 0);
        chk("rst_write_flag", 64'(write_flag), 0);
        chk("rst_new_loc", 64'(new_loc_clk), 0);
        chk("rst_step_count", 64'(step_count), 0);
        chk("rst_overrun", 64'(overrun), 0);
        chk("rst_ant_set", 64'(ant_set), 0);
        chk("rst_ant_d_in", 64'(ant_d_in), 0);
        chk("rst_cfg_err", 64'(cfg_bus.cfg_err), 0);
        chk("rst_cfg_ready", 64'(cfg_bus.cfg_ready), 0);
        chk("rst_render", 64'({render_ant, render_id}), 0);
        Reset = 1'b0;
        step();

        // Load phase
        setup_mode = 1'b1;
        step();
        chk("load_state", 64'(state), 64'(LOAD));
        chk("load_ready", 64'(cfg_bus.cfg_ready), 1);
        send(2, 34'h2A5A5A5A5);
        r64 = {$urandom, $urandom};
        send(5, r64[AB-1:0]);
        chk("cfg_err_set", 64'(cfg_bus.cfg_err), 1);
        for (int k = 0; k < 10; k++) begin
            r64 = {$urandom, $urandom};
            id  = int'($urandom_range(0, 7));
            send(id, r64[AB-1:0]);
        end
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_id    = 3'd1;
        setup_mode        = 1'b0;
        #1;
        chk("ready_drop", 64'(cfg_bus.cfg_ready), 0);
        step();
        cfg_bus.cfg_valid = 1'b0;
        chk("leave_load_state", 64'(state), 64'(IDLE));
        chk("cfg_err_sticky", 64'(cfg_bus.cfg_err), 1);

        // Timed sweeps
        push_sweep(N); push_done(1, N, 0);
        push_sweep(N); push_done(2, N, SD + 6);
        push_sweep(N); push_done(3, N, SD + 6);
        run_en = 1'b1;
        wait_done(120);
        run_en = 1'b0;
        step();

        // Manual sweep with a 3-cycle busy stall at idx=1
        push_sweep(N); push_done(4, N + 3, 0);
        step_req = 1'b1;
        step();
        step_req = 1'b0;
        step();
        ant_busy = 4'b0010;
        repeat (3) step();
        ant_busy = '0;
        wait_done(20);
        chk("overrun_clear", 64'(overrun), 0);

        // Manual sweep with a second step_req edge mid-sweep
        push_sweep(N); push_done(5, N, 0);
        step_req = 1'b1;
        step();
        step_req = 1'b0;
        step();
        step_req = 1'b1;
        step();
        step_req = 1'b0;
        chk("overrun_set", 64'(overrun), 1);
        wait_done(20);

        // Abort at idx=2
        push_sweep(2);
        step_req = 1'b1;
        step();
        step_req = 1'b0;
        step();
        step();
        setup_mode = 1'b1;
        step();
        chk("abort_state", 64'(state), 64'(LOAD));
        chk("abort_move", 64'(move_now), 0);
        chk("abort_write", 64'(write_flag), 0);
        repeat (5) step();
        chk("abort_step_count", 64'(step_count), 5);
        setup_mode = 1'b0;
        step();
        step();
        chk("abort_idle", 64'(state), 64'(IDLE));

        // Render: directed then random
        ax[0] = 8'd78; ay[0] = 7'd58;
        ax[1] = 8'd10; ay[1] = 7'd10;
        ax[2] = 8'd20; ay[2] = 7'd20;
        ax[3] = 8'd78; ay[3] = 7'd58;
        rx = 8'd78; ry = 7'd58;
        apply_render();
        rx = 8'd79;
        apply_render();
        ax[0] = 8'd1;
        rx = 8'd78;
        apply_render();
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < N; i++) begin
                ax[i] = 8'(76 + $urandom_range(0, 3));
                ay[i] = 7'(57 + $urandom_range(0, 1));
            end
            rx = 8'(76 + $urandom_range(0, 3));
            ry = 7'(57 + $urandom_range(0, 1));
            apply_render();
        end
        step();

        // Reset in the middle of a sweep
        push_sweep(2);
        step_req = 1'b1;
        step();
        step_req = 1'b0;
        step();
        @(negedge Clk);
        #1;
        Reset = 1'b1;
        step();
        chk("mid_rst_state", 64'(state), 64'(IDLE));
        chk("mid_rst_move", 64'(move_now), 0);
        chk("mid_rst_write", 64'(write_flag), 0);
        chk("mid_rst_new_loc", 64'(new_loc_clk), 0);
        chk("mid_rst_step_count", 64'(step_count), 0);
        chk("mid_rst_overrun", 64'(overrun), 0);
        chk("mid_rst_cfg_err", 64'(cfg_bus.cfg_err), 0);
        chk("mid_rst_ant_set", 64'(ant_set), 0);
        chk("mid_rst_ant_d_in", 64'(ant_d_in), 0);
        chk("mid_rst_render", 64'({render_ant, render_id}), 0);
        Reset = 1'b0;
        step();
        step();

        chk("q_set_empty", 64'(q_set.size()), 0);
        chk("q_move_empty", 64'(q_move.size()), 0);
        chk("q_done_empty", 64'(q_done.size()), 0);
        chk("q_rend_empty", 64'(q_rend.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
